mem_port_arbiter: RTL

- Shares the core's single 32-bit memory port between two requesters: the fetch stage (instruction port, read-only) and the memory stage (data port, read/write).
- Sits between `fetch`/`memory` and the external memory interface.
- Sequences one outstanding transaction at a time and routes responses back to the owner.
- Data has fixed priority over fetch, with an anti-starvation override for fetch and a response timeout.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between the fetch (read-only) and data
// (read/write) requesters. One transaction is outstanding at a time; data has
// fixed priority, fetch gets an anti-starvation override, and a response
// timeout synthesises an error response to the owner.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | arbitrating; winner (or locked winner) presented to memory
//   ST_WAIT | request accepted; waiting for mem_rvalid_i or the timeout
module mem_port_arbiter #(
    parameter int unsigned MAX_STREAK     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o
);

    localparam int unsigned SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        state;
    logic          owner_data;   // 1 = data port owns the outstanding transaction
    logic          lock_valid;
    logic          lock_data;
    logic [SW-1:0] streak;
    logic [7:0]    tmo_cnt;

    logic          win_valid;
    logic          win_data;
    logic          grant;
    logic          rsp_normal;
    logic          rsp_tmo;
    logic [31:0]   sel_addr;

    // Arbitration: a locked winner is kept until granted, otherwise data has
    // priority unless fetch has waited through MAX_STREAK data grants.
    always_comb begin
        win_valid = 1'b0;
        win_data  = 1'b0;
        if (state == ST_IDLE) begin
            if (lock_valid) begin
                win_valid = 1'b1;
                win_data  = lock_data;
            end else if ((streak == STREAK_MAX) && if_req_i) begin
                win_valid = 1'b1;
                win_data  = 1'b0;
            end else if (d_req_i) begin
                win_valid = 1'b1;
                win_data  = 1'b1;
            end else if (if_req_i) begin
                win_valid = 1'b1;
                win_data  = 1'b0;
            end
        end
    end

    assign grant      = win_valid && mem_gnt_i;
    assign rsp_normal = (state == ST_WAIT) && mem_rvalid_i;
    assign rsp_tmo    = (state == ST_WAIT) && !mem_rvalid_i && (tmo_cnt == TMO_LAST);
    assign sel_addr   = win_data ? d_addr_i : if_addr_i;

    // Request, grant and response routing; everything is forced low while
    // reset is held so that live inputs cannot leak through to the outputs.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        if_rvalid_o = 1'b0;
        if_err_o    = 1'b0;
        if_rdata_o  = 32'h0;
        d_rvalid_o  = 1'b0;
        d_err_o     = 1'b0;
        d_rdata_o   = 32'h0;
        busy_o      = 1'b0;
        if (reset) begin
            busy_o = (state == ST_WAIT);
            if (win_valid) begin
                mem_req_o  = 1'b1;
                mem_addr_o = sel_addr & 32'hFFFF_FFFC;
                if (win_data) begin
                    mem_we_o    = d_we_i;
                    mem_be_o    = d_be_i;
                    mem_wdata_o = d_wdata_i;
                    d_gnt_o     = mem_gnt_i;
                end else begin
                    mem_be_o    = 4'b1111;
                    if_gnt_o    = mem_gnt_i;
                end
            end
            if (rsp_normal || rsp_tmo) begin
                if (owner_data) begin
                    d_rvalid_o = 1'b1;
                    d_err_o    = rsp_tmo;
                    d_rdata_o  = rsp_normal ? mem_rdata_i : 32'h0;
                end else begin
                    if_rvalid_o = 1'b1;
                    if_err_o    = rsp_tmo;
                    if_rdata_o  = rsp_normal ? mem_rdata_i : 32'h0;
                end
            end
        end
    end

    // Transaction sequencing, lock capture, streak and timeout tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner_data <= 1'b0;
            lock_valid <= 1'b0;
            lock_data  <= 1'b0;
            streak     <= '0;
            tmo_cnt    <= 8'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state      <= ST_WAIT;
                        owner_data <= win_data;
                        lock_valid <= 1'b0;
                        tmo_cnt    <= 8'h0;
                        if (win_data && if_req_i) begin
                            if (streak != STREAK_MAX) begin
                                streak <= streak + SW'(1);
                            end
                        end else begin
                            streak <= '0;
                        end
                    end else if (win_valid) begin
                        lock_valid <= 1'b1;
                        lock_data  <= win_data;
                    end
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'h1;
                    if (rsp_normal || rsp_tmo) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
